// File: rtl/morse_key_sequencer.sv
// Front-end sequencer for the morse decoder: synchronises a raw key level, times marks
// and spaces against UNIT, and emits dot/dash/valid, letter-gap and word-gap pulses.
`timescale 1ns/1ps
module morse_key_sequencer #(
    parameter int UNIT  = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       key,
    output logic       dot,
    output logic       dash,
    output logic       valid,
    output logic       lg,
    output logic       wg,
    output logic       err,
    output logic       busy,
    output logic [2:0] sym_cnt
);
    typedef enum logic [1:0] {IDLE, MARK, SPACE, LGAP} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT);
    localparam logic [CNT_W-1:0] LG_CNT   = CNT_W'(3 * UNIT);
    localparam logic [CNT_W-1:0] WG_CNT   = CNT_W'(7 * UNIT);
    localparam logic [2:0]       SYM_MAX  = 3'd5;

    state_t           state;
    logic             key_p0;
    logic             key_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             is_dot;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign cnt_inc = sat_inc(cnt);
    assign is_dot  = (cnt < DASH_MIN);

    // Stage p0 -> s: two-flop synchroniser for the asynchronous key pin
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            key_p0 <= 1'b0;
            key_s  <= 1'b0;
        end else begin
            key_p0 <= key;
            key_s  <= key_p0;
        end
    end

    // Stage s -> outputs: duration timing FSM with registered control pulses
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            sym_cnt <= '0;
            dot     <= 1'b0;
            dash    <= 1'b0;
            valid   <= 1'b0;
            lg      <= 1'b0;
            wg      <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            dot   <= 1'b0;
            dash  <= 1'b0;
            valid <= 1'b0;
            lg    <= 1'b0;
            wg    <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                cnt     <= '0;
                sym_cnt <= '0;
                err     <= 1'b0;
                busy    <= 1'b0;
            end else begin
                // Overrun flag stays visible through the lg cycle so the decoder can see it
                if (lg) err <= 1'b0;
                case (state)
                    IDLE: begin
                        if (key_s) begin
                            state <= MARK;
                            cnt   <= CNT_ONE;
                            busy  <= 1'b1;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    MARK: begin
                        if (key_s) begin
                            cnt <= cnt_inc;
                        end else begin
                            if (sym_cnt < SYM_MAX) begin
                                dot     <= is_dot;
                                dash    <= ~is_dot;
                                valid   <= 1'b1;
                                sym_cnt <= sym_cnt + 3'd1;
                            end else begin
                                err <= 1'b1;
                            end
                            state <= SPACE;
                            cnt   <= CNT_ONE;
                        end
                    end
                    SPACE: begin
                        if (key_s) begin
                            state <= MARK;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc == LG_CNT) begin
                                lg      <= 1'b1;
                                sym_cnt <= '0;
                                state   <= LGAP;
                            end
                        end
                    end
                    LGAP: begin
                        if (key_s) begin
                            state <= MARK;
                            cnt   <= CNT_ONE;
                        end else if (cnt_inc == WG_CNT) begin
                            wg    <= 1'b1;
                            state <= IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_morse_key_sequencer.sv
// Bench for morse_key_sequencer: a run-length reference model over a directed+random key
// stream, plus directed reset and enable scenarios.
`timescale 1ns/1ps
module tb_morse_key_sequencer;
    localparam int UNIT  = 4;
    localparam int CNT_W = 8;
    localparam int NMAX  = 8000;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic       key;
    logic       dot, dash, valid, lg, wg, err, busy;
    logic [2:0] sym_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    bit         k_arr  [NMAX];
    int         e_pulse[NMAX];  // 0 none, 1 dot, 2 dash, 3 lg, 4 wg
    bit         e_err  [NMAX];
    bit         e_busy [NMAX];
    logic [2:0] e_sym  [NMAX];
    int         n_len = 0;

    morse_key_sequencer #(.UNIT(UNIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr), .en(en), .key(key),
        .dot(dot), .dash(dash), .valid(valid), .lg(lg), .wg(wg),
        .err(err), .busy(busy), .sym_cnt(sym_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic seg(input bit lvl, input int len);
        for (int j = 0; j < len; j++) begin
            k_arr[n_len] = lvl;
            n_len++;
        end
    endtask

    task automatic fill_err(input int from, input bit v);
        for (int j = from; j < NMAX; j++) e_err[j] = v;
    endtask

    task automatic fill_busy(input int from, input bit v);
        for (int j = from; j < NMAX; j++) e_busy[j] = v;
    endtask

    task automatic fill_sym(input int from, input logic [2:0] v);
        for (int j = from; j < NMAX; j++) e_sym[j] = v;
    endtask

    // Walks the key stream as alternating mark/space runs; a sample at index i affects
    // the output observed two edges later (index i+2).
    task automatic build_model();
        int i, s, len, p, g_s, g_len, nsym, t;
        for (int j = 0; j < NMAX; j++) begin
            e_pulse[j] = 0; e_err[j] = 1'b0; e_busy[j] = 1'b0; e_sym[j] = 3'd0;
        end
        i = 0;
        nsym = 0;
        while (i < n_len) begin
            if (!k_arr[i]) begin
                i++;
            end else begin
                s = i;
                while (i < n_len && k_arr[i]) i++;
                len = i - s;
                p = i + 2;
                fill_busy(s + 2, 1'b1);
                if (nsym < 5) begin
                    nsym++;
                    e_pulse[p] = (len < 2 * UNIT) ? 1 : 2;
                    fill_sym(p, 3'(nsym));
                end else begin
                    fill_err(p, 1'b1);
                end
                g_s = i;
                while (i < n_len && !k_arr[i]) i++;
                g_len = i - g_s;
                if (g_len >= 3 * UNIT) begin
                    t = g_s + 3 * UNIT + 1;
                    e_pulse[t] = 3;
                    nsym = 0;
                    fill_sym(t, 3'd0);
                    fill_err(t + 1, 1'b0);
                end
                if (g_len >= 7 * UNIT) begin
                    t = g_s + 7 * UNIT + 1;
                    e_pulse[t] = 4;
                    fill_busy(t, 1'b0);
                end
            end
        end
    endtask

    function automatic logic [9:0] exp_vec(input int j);
        logic ed, eh, ev, el, ew;
        ed = (e_pulse[j] == 1);
        eh = (e_pulse[j] == 2);
        ev = ed | eh;
        el = (e_pulse[j] == 3);
        ew = (e_pulse[j] == 4);
        return {ed, eh, ev, el, ew, e_err[j], e_busy[j], e_sym[j]};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {dot, dash, valid, lg, wg, err, busy, sym_cnt};
    endfunction

    initial begin
        int mlen, glen, pick;
        clr = 1'b1;
        en  = 1'b1;
        key = 1'b0;

        // Directed patterns followed by random marks and spaces
        seg(1, 7);  seg(0, 30);
        seg(1, 8);  seg(0, 30);
        seg(1, 1);  seg(0, 30);
        seg(1, 4);  seg(0, 4);  seg(1, 12); seg(0, 40);
        seg(1, 4);  seg(0, 11); seg(1, 4);  seg(0, 30);
        seg(1, 4);  seg(0, 12); seg(1, 4);  seg(0, 30);
        for (int r = 0; r < 6; r++) begin seg(1, 4); seg(0, 4); end
        seg(0, 30);
        seg(1, 300); seg(0, 30);
        for (int r = 0; r < 80; r++) begin
            mlen = int'($urandom_range(1, 14));
            pick = int'($urandom_range(0, 2));
            glen = (pick == 0) ? int'($urandom_range(1, 10)) :
                   (pick == 1) ? int'($urandom_range(11, 20)) : int'($urandom_range(21, 35));
            seg(1, mlen);
            seg(0, glen);
        end
        seg(0, 40);
        build_model();

        repeat (3) @(negedge clk);
        chk("reset_state", 32'(obs_vec()), 32'd0);
        clr = 1'b0;

        for (int i = 0; i < n_len + 3; i++) begin
            @(negedge clk);
            if (i > 0) chk($sformatf("stream[%0d]", i - 1), 32'(obs_vec()), 32'(exp_vec(i - 1)));
            key = (i < n_len) ? k_arr[i] : 1'b0;
        end
        repeat (5) @(negedge clk);

        // Asynchronous clear during a dash
        key = 1'b1;
        repeat (5) @(negedge clk);
        chk("busy_before_clr", 32'(busy), 32'd1);
        #2 clr = 1'b1;
        #1 chk("clr_async", 32'(obs_vec()), 32'd0);
        key = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            chk("post_clr_quiet", 32'({dot, dash, valid, lg, wg, busy}), 32'd0);
        end

        // Key held down through reset release counts as a mark start
        clr = 1'b1;
        key = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        repeat (20) @(negedge clk);
        key = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (valid) break;
        end
        chk("held_reset_dash", 32'({dot, dash, valid, sym_cnt}), 32'({3'b011, 3'd1}));
        repeat (40) @(negedge clk);
        chk("held_reset_idle", 32'({busy, sym_cnt}), 32'd0);

        // Enable drop in the middle of a space
        key = 1'b1;
        repeat (4) @(negedge clk);
        key = 1'b0;
        repeat (6) @(negedge clk);
        chk("space_before_en", 32'({busy, sym_cnt}), 32'({1'b1, 3'd1}));
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        chk("en_drop_idle", 32'({busy, sym_cnt, err}), 32'd0);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            chk("post_en_quiet", 32'({dot, dash, valid, lg, wg, busy}), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
